// File: rtl/y_fetch_pkg.sv
// Shared types and constants for the y_fetch_pc fetch stage.
// The optional alignment check (FETCH_ALIGN_CHECK_EN) uses is_word_aligned.
package y_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/y_fetch_pc_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit's view.
interface y_fetch_pc_if #(
    parameter int unsigned WIDTH = 32
);
    import y_fetch_pkg::*;

    logic                 redirect_valid;
    logic [WIDTH-1:0]     redirect_pc;
    logic                 imem_req;
    logic [WIDTH-1:0]     imem_addr;
    logic                 imem_ack;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 ins_valid;
    logic [INSTR_W-1:0]   ins_data;
    logic [WIDTH-1:0]     ins_pc;
    logic                 ins_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, ins_ready,
        output imem_req, imem_addr, ins_valid, ins_data, ins_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, ins_ready,
        input  imem_req, imem_addr, ins_valid, ins_data, ins_pc
    );

endinterface

// File: rtl/y_pc_next_sel.sv
// Next-PC 2:1 mux bank: one single-bit mux per PC bit, sel picks b (redirect) over a.
module y_pc_next_sel #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = sel ? b[i] : a[i];
    end

endmodule

// File: rtl/y_fetch_pc.sv
// Program counter and fetch stage: req/ack to instruction memory, 1-entry output register.
// Optional macro FETCH_ALIGN_CHECK_EN rejects unaligned redirects and adds the misalign port.
module y_fetch_pc
    import y_fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      INC      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    y_fetch_pc_if.master  bus
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic          misalign
`endif
);

    fetch_state_e         state_r;
    logic [WIDTH-1:0]     pc_r;
    logic [WIDTH-1:0]     drain_addr_r;
    logic                 req_hold_r;
    logic                 ins_valid_r;
    logic [INSTR_W-1:0]   ins_data_r;
    logic [WIDTH-1:0]     ins_pc_r;

    logic                 redir_acc_s;
    logic                 req_s;
    logic [WIDTH-1:0]     addr_s;
    logic                 ack_s;
    logic                 load_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     pc_inc_s;
    logic [WIDTH-1:0]     pc_next_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_acc_s = bus.redirect_valid & is_word_aligned(bus.redirect_pc[1:0]);
`else
    assign redir_acc_s = bus.redirect_valid;
`endif

    assign pc_inc_s = pc_r + WIDTH'(INC);

    y_pc_next_sel #(
        .WIDTH (WIDTH)
    ) u_next_sel (
        .sel (redir_acc_s),
        .a   (pc_inc_s),
        .b   (bus.redirect_pc),
        .y   (pc_next_s)
    );

    // Request only when the output slot is free this cycle, or keep an already raised request.
    always_comb begin
        req_s  = 1'b0;
        addr_s = {WIDTH{1'b0}};
        case (state_r)
            REQ: begin
                if (req_hold_r || !ins_valid_r || bus.ins_ready) begin
                    req_s  = 1'b1;
                    addr_s = pc_r;
                end else begin
                    req_s  = 1'b0;
                    addr_s = {WIDTH{1'b0}};
                end
            end
            DRAIN: begin
                req_s  = 1'b1;
                addr_s = drain_addr_r;
            end
            default: begin
                req_s  = 1'b0;
                addr_s = {WIDTH{1'b0}};
            end
        endcase
    end

    assign ack_s    = req_s & bus.imem_ack;
    assign load_s   = (state_r == REQ) & ack_s & ~redir_acc_s;
    assign accept_s = ins_valid_r & bus.ins_ready;

    // Fetch FSM: state, architectural PC, the address held while draining a cancelled fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            drain_addr_r <= {WIDTH{1'b0}};
            req_hold_r   <= 1'b0;
        end else begin
            if (redir_acc_s || load_s) begin
                pc_r <= pc_next_s;
            end
            case (state_r)
                IDLE: begin
                    state_r    <= REQ;
                    req_hold_r <= 1'b0;
                end
                REQ: begin
                    if (redir_acc_s && req_s && !bus.imem_ack) begin
                        state_r      <= DRAIN;
                        drain_addr_r <= pc_r;
                        req_hold_r   <= 1'b0;
                    end else begin
                        state_r    <= REQ;
                        req_hold_r <= req_s & ~bus.imem_ack & ~redir_acc_s;
                    end
                end
                DRAIN: begin
                    req_hold_r <= 1'b0;
                    // The cancelled fetch completes here; its word is dropped.
                    if (bus.imem_ack) begin
                        state_r <= REQ;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    req_hold_r <= 1'b0;
                end
            endcase
        end
    end

    // Output register: flush wins, then a new word, then clear on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_valid_r <= 1'b0;
            ins_data_r  <= {INSTR_W{1'b0}};
            ins_pc_r    <= {WIDTH{1'b0}};
        end else if (redir_acc_s) begin
            ins_valid_r <= 1'b0;
        end else if (load_s) begin
            ins_valid_r <= 1'b1;
            ins_data_r  <= bus.imem_rdata;
            ins_pc_r    <= pc_r;
        end else if (accept_s) begin
            ins_valid_r <= 1'b0;
        end
    end

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = addr_s;
    assign bus.ins_valid = ins_valid_r;
    assign bus.ins_data  = ins_data_r;
    assign bus.ins_pc    = ins_pc_r;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_r;

    // One-cycle flag for a redirect rejected because of its low address bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= bus.redirect_valid & ~is_word_aligned(bus.redirect_pc[1:0]);
        end
    end

    assign misalign = misalign_r;
`endif

endmodule

// File: tb/tb_y_fetch_pc.sv
// Scoreboard bench for y_fetch_pc: directed start-up/stall checks, then random redirects,
// random memory latency and decode back-pressure against a delivered-stream model.
module tb_y_fetch_pc;
    import y_fetch_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    y_fetch_pc_if #(.WIDTH(WIDTH)) bus ();

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;
`endif

    y_fetch_pc #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0000_0000),
        .INC      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign (misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    int          n_checks = 0;
    int          n_fails  = 0;
    int          n_deliv  = 0;
    logic [31:0] redir_q[$];
    bit          ack_tied;
    bit          waiting;
    int          delay;
    int          cnt;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit redirect_taken(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return (t[1:0] == 2'b00);
`else
        return 1'b1;
`endif
    endfunction

    task automatic respond();
        if (ack_tied) begin
            bus.imem_ack = 1'b1;
        end else if (bus.imem_req) begin
            if (!waiting) begin
                waiting = 1'b1;
                delay   = $urandom_range(0, 3);
                cnt     = 0;
            end
            if (cnt == delay) begin
                bus.imem_ack = 1'b1;
                waiting      = 1'b0;
            end else begin
                bus.imem_ack = 1'b0;
                cnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            waiting      = 1'b0;
        end
    endtask

    task automatic drive_cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        bus.ins_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (rv && rst_n && redirect_taken(rpc)) redir_q.push_back(rpc);
        #1;
        respond();
    endtask

    // Monitor: delivered words must follow the sequential stream from the latest redirect target.
    initial begin : monitor
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        bit          flush_chk;
        bit          pend;
        int          idle_cnt;
`ifdef FETCH_ALIGN_CHECK_EN
        bit          mis_prev;
        mis_prev = 1'b0;
`endif
        exp_pc    = 32'h0;
        pend_addr = 32'h0;
        flush_chk = 1'b0;
        pend      = 1'b0;
        idle_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc    = 32'h0;
                flush_chk = 1'b0;
                pend      = 1'b0;
                idle_cnt  = 0;
                redir_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                mis_prev  = 1'b0;
`endif
            end else begin
                if (flush_chk) check(!bus.ins_valid, "flush", 32'(bus.ins_valid), 32'h0);
                if (pend) check(bus.imem_req && bus.imem_addr == pend_addr, "req_hold",
                                bus.imem_addr, pend_addr);
`ifdef FETCH_ALIGN_CHECK_EN
                check(misalign == mis_prev, "misalign", 32'(misalign), 32'(mis_prev));
                mis_prev = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`endif
                if (bus.ins_valid && bus.ins_ready) begin
                    check(bus.ins_pc == exp_pc, "ins_pc", bus.ins_pc, exp_pc);
                    check(bus.ins_data == mem_word(exp_pc), "ins_data", bus.ins_data, mem_word(exp_pc));
                    exp_pc   = exp_pc + 32'd4;
                    n_deliv++;
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                end
                flush_chk = 1'b0;
                if (redir_q.size() > 0) begin
                    exp_pc    = redir_q.pop_front();
                    flush_chk = 1'b1;
                    idle_cnt  = 0;
                end
                pend      = bus.imem_req && !bus.imem_ack;
                pend_addr = bus.imem_addr;
                if (idle_cnt > 60) begin
                    check(1'b0, "watchdog", 32'(idle_cnt), 32'd60);
                    idle_cnt = 0;
                end
            end
        end
    end

    initial begin : stim
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        int          since_rst;
        bus.ins_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_ack       = 1'b0;
        ack_tied           = 1'b1;
        waiting            = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check(bus.imem_req == 1'b0, "rst_req", 32'(bus.imem_req), 32'h0);
        check(bus.imem_addr == 32'h0, "rst_addr", bus.imem_addr, 32'h0);
        check(bus.ins_valid == 1'b0, "rst_valid", 32'(bus.ins_valid), 32'h0);
        check(bus.ins_data == 32'h0, "rst_data", bus.ins_data, 32'h0);
        check(bus.ins_pc == 32'h0, "rst_pc", bus.ins_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check(misalign == 1'b0, "rst_misalign", 32'(misalign), 32'h0);
`endif
        #20 rst_n = 1'b1;

        // Back-to-back fetch with same-cycle ack.
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0);
            @(negedge clk);
            check(bus.imem_req && bus.imem_addr == 32'(4 * i), "seq_addr", bus.imem_addr, 32'(4 * i));
            if (i > 0) check(bus.ins_valid && bus.ins_pc == 32'(4 * (i - 1)), "seq_pc",
                             bus.ins_pc, 32'(4 * (i - 1)));
        end

        // Decode stall: no request, output register holds.
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check(bus.imem_req == 1'b0, "stall_req", 32'(bus.imem_req), 32'h0);
            check(bus.ins_valid && bus.ins_pc == 32'd12, "stall_pc", bus.ins_pc, 32'd12);
            check(bus.ins_data == mem_word(32'd12), "stall_data", bus.ins_data, mem_word(32'd12));
        end
        drive_cycle(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check(bus.imem_req && bus.imem_addr == 32'd16, "resume_addr", bus.imem_addr, 32'd16);

        // Unaligned redirect, then a few sequential cycles.
        drive_cycle(1'b1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 32'h0);

        // Random phase with variable memory latency and one asynchronous reset mid-run.
        ack_tied  = 1'b0;
        waiting   = 1'b0;
        since_rst = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check(bus.imem_req == 1'b0 && bus.ins_valid == 1'b0, "midrst_out",
                      {bus.imem_req, bus.ins_valid}, 32'h0);
                check(bus.ins_pc == 32'h0 && bus.imem_addr == 32'h0, "midrst_pc", bus.ins_pc, 32'h0);
                waiting            = 1'b0;
                bus.redirect_valid = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #3 rst_n  = 1'b1;
                since_rst = 0;
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 7) == 0) && (since_rst >= 2);
            case ($urandom_range(0, 7))
                0:       rpc = 32'hFFFF_FFF8;
                1:       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b10};
                default: rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            endcase
            drive_cycle(rdy, rv, rpc);
            since_rst++;
        end

        drive_cycle(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check(n_deliv > 500, "deliveries", 32'(n_deliv), 32'd500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
